perf_report_sched: RTL

- Scheduler that owns the link between the cache performance counters and the UART transmitter.
- On a periodic tick or a manual request it snapshots NCNT 8-bit counter values and serializes them into one framed packet: header, NCNT data bytes, checksum.
- Each byte goes through a start/busy handshake with the UART TX, so the packet never depends on fixed inter-byte spacing.
- Placement: between the counter block and the UART TX start/data inputs.

---
 rtl/perf_pkg.sv | 33 +++
 rtl/perf_interval_timer.sv | 34 +++
 rtl/perf_report_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types, defaults and helpers for the performance-report scheduler.
// Frame layout: header byte, NCNT counter bytes, then a mod-256 checksum of the counter bytes.
package perf_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWaitAck  = 3'd2,
        StWaitDone = 3'd3,
        StNext     = 3'd4
    } state_e;

    localparam logic [7:0]  HDR_DEFAULT  = 8'hA5;
    localparam int unsigned NCNT_DEFAULT = 6;
    localparam int unsigned MAX_NCNT     = 16;

    function automatic int unsigned frame_len(input int unsigned ncnt);
        return ncnt + 2;
    endfunction

    localparam int unsigned FRAME_LEN = frame_len(NCNT_DEFAULT);

    // Sum of the low n bytes of v, wrapping at 256; the header is never part of v.
    function automatic logic [7:0] sum8(input logic [MAX_NCNT*8-1:0] v, input int unsigned n);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < int'(MAX_NCNT); k++) begin
            if (k < int'(n)) s = s + v[8*k +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/perf_interval_timer.sv
// Free-running report interval timer: one-cycle tick every PERIOD cycles while enabled.
// Disabling holds the count at zero, so re-enabling always restarts a full period.
module perf_interval_timer #(
    parameter int unsigned PERIOD = 600
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned W = $clog2(PERIOD);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == W'(PERIOD - 1)) begin
            tick_o = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/perf_report_sched.sv
// Snapshots the cache performance counters on a tick or trigger and feeds them to the UART TX
// one byte at a time with a start/busy handshake, holding at most one queued request.
module perf_report_sched
    import perf_pkg::*;
#(
    parameter int unsigned NCNT   = NCNT_DEFAULT,
    parameter int unsigned PERIOD = 600,
    parameter logic [7:0]  HDR    = HDR_DEFAULT,
    parameter int unsigned ACK_TO = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en_i,
    input  logic            trig_i,
    input  logic [NCNT*8-1:0] cnt_i,
    input  logic            tx_busy_i,
    output logic            tx_start_o,
    output logic [7:0]      tx_data_o,
    output logic            snap_o,
    output logic            frame_active_o,
    output logic [7:0]      overrun_o
);

    localparam int unsigned LAST = NCNT + 1;
    localparam int unsigned IW   = $clog2(frame_len(NCNT));
    localparam int unsigned AW   = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       ack_q, ack_d;
    logic [NCNT*8-1:0]   snap_reg_q, snap_reg_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          txd_q, txd_d;
    logic [7:0]          ovr_q, ovr_d;
    logic                pend_q, pend_d;
    logic                snap_q, snap_d;
    logic                fa_q, fa_d;

    logic                tick, req, do_snap, consume;
    logic [7:0]          next_byte;
    logic [MAX_NCNT*8-1:0] cnt_ext;

    perf_interval_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (en_i),
        .tick_o (tick)
    );

    assign req = tick | trig_i;

    // Byte sent after the current index: data byte idx_q, or the checksum once past the data.
    always_comb begin
        next_byte = chk_q;
        for (int k = 0; k < int'(NCNT); k++) begin
            if (idx_q == IW'(k)) next_byte = snap_reg_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ack_d      = ack_q;
        snap_reg_d = snap_reg_q;
        chk_d      = chk_q;
        txd_d      = txd_q;
        ovr_d      = ovr_q;
        pend_d     = pend_q;
        snap_d     = 1'b0;
        fa_d       = fa_q;
        do_snap    = 1'b0;
        consume    = 1'b0;
        cnt_ext    = '0;
        cnt_ext[NCNT*8-1:0] = cnt_i;

        unique case (state_q)
            StIdle: begin
                // A request queued on the very last cycle of a frame is served from here.
                if (req || pend_q) begin
                    do_snap = 1'b1;
                    consume = 1'b1;
                end
            end
            StStart: begin
                state_d = StWaitAck;
                ack_d   = '0;
            end
            StWaitAck: begin
                if (tx_busy_i) begin
                    state_d = StWaitDone;
                end else if (ack_q == AW'(ACK_TO - 1)) begin
                    state_d = StNext;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy_i) state_d = StNext;
            end
            StNext: begin
                if (idx_q != IW'(LAST)) begin
                    idx_d   = idx_q + 1'b1;
                    txd_d   = next_byte;
                    state_d = StStart;
                end else if (pend_q) begin
                    do_snap = 1'b1;
                    consume = 1'b1;
                end else begin
                    fa_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_snap) begin
            snap_reg_d = cnt_i;
            chk_d      = sum8(cnt_ext, NCNT);
            snap_d     = 1'b1;
            fa_d       = 1'b1;
            idx_d      = '0;
            txd_d      = HDR;
            state_d    = StStart;
        end

        if (consume) pend_d = 1'b0;
        if (req && fa_q) begin
            if (pend_q && !consume) begin
                if (ovr_q != 8'hFF) ovr_d = ovr_q + 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ack_q      <= '0;
            snap_reg_q <= '0;
            chk_q      <= '0;
            txd_q      <= '0;
            ovr_q      <= '0;
            pend_q     <= 1'b0;
            snap_q     <= 1'b0;
            fa_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ack_q      <= ack_d;
            snap_reg_q <= snap_reg_d;
            chk_q      <= chk_d;
            txd_q      <= txd_d;
            ovr_q      <= ovr_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            fa_q       <= fa_d;
        end
    end

    assign tx_start_o     = (state_q == StStart);
    assign tx_data_o      = txd_q;
    assign snap_o         = snap_q;
    assign frame_active_o = fa_q;
    assign overrun_o      = ovr_q;

endmodule
